modmul_arbiter: RTL and testbench

MODMUL_ARBITER -- requirements
Module: modmul_arbiter

---
 rtl/modmul_pkg.sv | 21 ++
 rtl/rr_pick.sv | 34 +++
 rtl/modmul_arbiter.sv | 161 ++++++++++++++++
 tb/tb_modmul_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/modmul_pkg.sv
// Shared definitions for the modular-multiply arbiter and its engine controller:
// FSM encoding, default geometry and an index-width helper.
package modmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_W       = 32;
  localparam int DEF_TIMEOUT = 1024;

  // A single requester still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request at or above the pointer, wrapping to 0.
// Purely combinational; reports the winner as one-hot and as an index.
module rr_pick
  import modmul_pkg::*;
#(
  parameter  int N  = DEF_N_REQ,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    logic found;
    int   j;
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    j        = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found       = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = IW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/modmul_arbiter.sv
// Shares one modular-multiply engine among N_REQ requesters: round-robin grant,
// single-cycle start, completion or timeout abort, one-cycle response strobe.
module modmul_arbiter
  import modmul_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ*W-1:0] req_n,
  output logic [N_REQ-1:0]   grant,
  output logic [W-1:0]       eng_a,
  output logic [W-1:0]       eng_b,
  output logic [W-1:0]       eng_n,
  output logic               eng_start,
  input  logic               eng_done,
  input  logic [W-1:0]       eng_result,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_data,
  output logic               rsp_err
);

  localparam int IW = idx_width(N_REQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [W-1:0]       eng_a_q, eng_a_d;
  logic [W-1:0]       eng_b_q, eng_b_d;
  logic [W-1:0]       eng_n_q, eng_n_d;
  logic               eng_start_q, eng_start_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [W-1:0]       rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic [N_REQ-1:0]   pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic [W-1:0] a_arr [N_REQ];
  logic [W-1:0] b_arr [N_REQ];
  logic [W-1:0] n_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign a_arr[g] = req_a[g*W +: W];
    assign b_arr[g] = req_b[g*W +: W];
    assign n_arr[g] = req_n[g*W +: W];
  end

  rr_pick #(.N(N_REQ)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    eng_a_d     = eng_a_q;
    eng_b_d     = eng_b_q;
    eng_n_d     = eng_n_q;
    eng_start_d = 1'b0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          win_d       = pick_idx;
          grant_d     = pick_onehot;
          eng_a_d     = a_arr[pick_idx];
          eng_b_d     = b_arr[pick_idx];
          eng_n_d     = n_arr[pick_idx];
          eng_start_d = 1'b1;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        // eng_done here cannot belong to this start pulse, so it is ignored.
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done) begin
          rsp_data_d  = eng_result;
          rsp_valid_d = grant_q;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d  = '0;
          rsp_valid_d = grant_q;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        grant_d = '0;
        ptr_d   = (win_q == IDX_LAST) ? '0 : win_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      eng_a_q     <= '0;
      eng_b_q     <= '0;
      eng_n_q     <= '0;
      eng_start_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      eng_a_q     <= eng_a_d;
      eng_b_q     <= eng_b_d;
      eng_n_q     <= eng_n_d;
      eng_start_q <= eng_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign grant     = grant_q;
  assign eng_a     = eng_a_q;
  assign eng_b     = eng_b_q;
  assign eng_n     = eng_n_q;
  assign eng_start = eng_start_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_modmul_arbiter.sv
// Directed bench for modmul_arbiter with a hand-driven engine (TIMEOUT = 16).
module tb_modmul_arbiter;

  localparam int N_REQ   = 4;
  localparam int W       = 32;
  localparam int TIMEOUT = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] req_a, req_b, req_n;
  logic [N_REQ-1:0]   grant;
  logic [W-1:0]       eng_a, eng_b, eng_n;
  logic               eng_start;
  logic               eng_done;
  logic [W-1:0]       eng_result;
  logic [N_REQ-1:0]   rsp_valid;
  logic [W-1:0]       rsp_data;
  logic               rsp_err;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int start_base;
  int w;

  logic [W-1:0] exp_a [N_REQ];
  logic [W-1:0] exp_b [N_REQ];
  logic [W-1:0] exp_n [N_REQ];

  modmul_arbiter #(.N_REQ(N_REQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_n      (req_n),
    .grant      (grant),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_n      (eng_n),
    .eng_start  (eng_start),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (eng_start) start_cnt++;

  // Advance one edge; outputs are read and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_a[0] = 32'd7;  exp_b[0] = 32'd9;  exp_n[0] = 32'd11;
    for (int i = 1; i < N_REQ; i++) begin
      exp_a[i] = 32'h100 + i;
      exp_b[i] = 32'h200 + i;
      exp_n[i] = 32'h300 + i;
    end
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i*W +: W] = exp_a[i];
      req_b[i*W +: W] = exp_b[i];
      req_n[i*W +: W] = exp_n[i];
    end
    rst = 1'b1; req = '0; eng_done = 1'b0; eng_result = '0;

    // Reset state
    tick(); tick();
    chk("rst_grant", grant, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_eng_a", eng_a, 0);
    rst = 1'b0;

    // Single requester; a stray eng_done during START must be ignored
    req = 4'b0001;
    tick();
    chk("single_grant", grant, 4'b0001);
    chk("single_start", eng_start, 1);
    chk("single_a", eng_a, 7);
    chk("single_b", eng_b, 9);
    chk("single_n", eng_n, 11);
    eng_done = 1'b1; eng_result = 32'hDEAD;
    tick();
    chk("single_start_pulse", eng_start, 0);
    chk("single_done_in_start", rsp_valid, 0);
    eng_done = 1'b0;
    tick();
    eng_done = 1'b1; eng_result = 32'd8;
    tick();
    eng_done = 1'b0; req = '0;
    chk("single_valid", rsp_valid, 4'b0001);
    chk("single_data", rsp_data, 8);
    chk("single_err", rsp_err, 0);
    chk("single_a_hold", eng_a, 7);
    tick();
    chk("single_valid_clr", rsp_valid, 0);
    chk("single_grant_clr", grant, 0);

    // Pointer is now 1; reset must return it to 0 before contention
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    start_base = start_cnt;
    for (int g = 0; g < 5; g++) begin
      w = g % N_REQ;
      tick();
      chk("cont_grant", grant, 64'(1) << w);
      chk("cont_start", eng_start, 1);
      chk("cont_a", eng_a, exp_a[w]);
      tick();
      eng_done = 1'b1; eng_result = 32'hA0 + w;
      tick();
      eng_done = 1'b0;
      chk("cont_valid", rsp_valid, 64'(1) << w);
      chk("cont_data", rsp_data, 32'hA0 + w);
      if (g == 4) req = '0;
      tick();
      chk("cont_idle_grant", grant, 0);
    end
    chk("cont_start_count", start_cnt - start_base, 5);

    // Timeout (pointer 1 -> requester 2)
    req = 4'b0100;
    tick();
    chk("to_grant", grant, 4'b0100);
    tick();
    repeat (15) tick();
    chk("to_not_early", rsp_valid, 0);
    tick();
    req = '0;
    chk("to_valid", rsp_valid, 4'b0100);
    chk("to_err", rsp_err, 1);
    chk("to_data", rsp_data, 0);
    tick();
    chk("to_err_clr", rsp_err, 0);
    chk("to_grant_clr", grant, 0);

    // Reset mid-WAIT (pointer 3 -> wraps to requester 1)
    req = 4'b0010;
    tick();
    chk("rw_grant", grant, 4'b0010);
    chk("rw_a", eng_a, exp_a[1]);
    tick(); tick();
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    chk("rw_grant_clr", grant, 0);
    chk("rw_start_clr", eng_start, 0);
    chk("rw_valid_clr", rsp_valid, 0);
    chk("rw_eng_a_clr", eng_a, 0);
    chk("rw_eng_b_clr", eng_b, 0);
    chk("rw_eng_n_clr", eng_n, 0);
    eng_done = 1'b1; eng_result = 32'hBEEF;
    tick();
    eng_done = 1'b0;
    tick();
    chk("rw_no_rsp", rsp_valid, 0);
    chk("idle_done_ignored", rsp_data, 0);
    req = 4'b0100;
    tick();
    chk("rw_regrant", grant, 4'b0100);
    chk("rw_regrant_a", eng_a, exp_a[2]);
    tick();
    eng_done = 1'b1; eng_result = 32'h77;
    tick();
    eng_done = 1'b0; req = '0;
    chk("rw_valid", rsp_valid, 4'b0100);
    chk("rw_data", rsp_data, 32'h77);
    tick();

    // Done coinciding with the last timeout count (pointer 3)
    req = 4'b1000;
    tick();
    chk("co_grant", grant, 4'b1000);
    tick();
    repeat (15) tick();
    chk("co_not_early", rsp_valid, 0);
    eng_done = 1'b1; eng_result = 32'h55AA;
    tick();
    eng_done = 1'b0; req = '0;
    chk("co_valid", rsp_valid, 4'b1000);
    chk("co_err", rsp_err, 0);
    chk("co_data", rsp_data, 32'h55AA);
    tick();

    // Early drop of req during WAIT (pointer 0)
    req = 4'b0010;
    tick();
    chk("ed_grant", grant, 4'b0010);
    tick();
    req = '0;
    tick();
    eng_done = 1'b1; eng_result = 32'h1234;
    tick();
    eng_done = 1'b0;
    chk("ed_valid", rsp_valid, 4'b0010);
    chk("ed_data", rsp_data, 32'h1234);
    chk("ed_err", rsp_err, 0);
    tick(); tick(); tick();
    chk("ed_no_regrant", grant, 0);
    chk("ed_no_start", eng_start, 0);
    chk("ed_no_valid", rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
